// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Purpose
//   Single-entry decode -> execute pipeline register with valid/ready
//   handshaking on both sides. It also handles three pipeline concerns:
//     * load-use hazard: a younger instruction that reads the destination of
//       a held load is not accepted. The load is released downstream on its
//       own, which leaves exactly one bubble, and each such bubble is counted.
//     * write-back bypass: a register-file write happening in the same cycle
//       as capture overrides the stale RD1/RD2 read data.
//     * held-entry refresh: while the entry is stalled, a write-back to one
//       of its source registers updates the held operand value.
//   A flush (branch redirect) kills the held entry and blocks capture of
//   the incoming instruction.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   in_*            : decoded instruction from decode/register file
//                     (valid/ready handshake)
//   wb_we/rd/wd     : write-back port of the register file (bypass source)
//   flush           : kill held and incoming instruction
//   out_*           : registered instruction towards execute
//                     (valid/ready handshake)
//   bubble_cnt      : saturating count of load-use bubbles inserted
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,

  // upstream (decode / register file)
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_rd1,
  input  logic [31:0]       in_rd2,
  input  logic [31:0]       in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_is_load,

  // write-back bypass
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [31:0]       wb_wd,

  // branch redirect
  input  logic              flush,

  // downstream (execute)
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [31:0]       out_rd1,
  output logic [31:0]       out_rd2,
  output logic [31:0]       out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_is_load,

  // statistics
  output logic [15:0]       bubble_cnt
);

  localparam logic [15:0] BUBBLE_MAX = 16'hFFFF;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              valid_reg,   valid_next;
  logic [31:0]       pc_reg,      pc_next;
  logic [4:0]        rs1_reg,     rs1_next;
  logic [4:0]        rs2_reg,     rs2_next;
  logic [4:0]        rd_reg,      rd_next;
  logic [31:0]       rd1_reg,     rd1_next;
  logic [31:0]       rd2_reg,     rd2_next;
  logic [31:0]       imm_reg,     imm_next;
  logic [CTRL_W-1:0] ctrl_reg,    ctrl_next;
  logic              is_load_reg, is_load_next;
  logic [15:0]       bubble_cnt_reg, bubble_cnt_next;

  // ---------------------------------------------------------------------------
  // Handshake and hazard detection
  // ---------------------------------------------------------------------------
  logic hazard;
  logic fire_in;
  logic fire_out;
  logic bubble_evt;

  // The incoming instruction reads the register that the held load has not
  // produced yet. x0 never creates a dependency.
  assign hazard = in_valid & valid_reg & is_load_reg & (rd_reg != 5'd0) &
                  ((rd_reg == in_rs1) | (rd_reg == in_rs2));

  assign in_ready = (~valid_reg | out_ready) & ~hazard & ~flush;

  assign fire_in  = in_valid & in_ready;
  assign fire_out = valid_reg & out_ready;

  // A bubble is the load leaving while its consumer is held back upstream.
  // A flush on the same edge kills the pipeline contents anyway, so that
  // edge is not counted as a load-use bubble.
  assign bubble_evt = hazard & fire_out & ~flush;

  // ---------------------------------------------------------------------------
  // Operand forwarding from the write-back port.
  // Index 0 is the rs1/RD1 operand and index 1 is the rs2/RD2 operand. The
  // same forwarding rule is used on the capture path (incoming operands) and
  // on the refresh path (operands of the held entry).
  // ---------------------------------------------------------------------------
  logic              wb_live;
  logic [1:0][4:0]   in_src;
  logic [1:0][4:0]   held_src;
  logic [1:0][31:0]  in_data;
  logic [1:0][31:0]  held_data;
  logic [1:0]        in_hit;
  logic [1:0]        held_hit;
  logic [1:0][31:0]  cap_data;
  logic [1:0][31:0]  ref_data;

  // A write to x0 is architecturally discarded, so it must never forward.
  assign wb_live = wb_we & (wb_rd != 5'd0);

  assign in_src    = {in_rs2,  in_rs1};
  assign held_src  = {rs2_reg, rs1_reg};
  assign in_data   = {in_rd2,  in_rd1};
  assign held_data = {rd2_reg, rd1_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign in_hit[gi]   = wb_live & (wb_rd == in_src[gi]);
      assign held_hit[gi] = wb_live & (wb_rd == held_src[gi]);
      assign cap_data[gi] = in_hit[gi]   ? wb_wd : in_data[gi];
      assign ref_data[gi] = held_hit[gi] ? wb_wd : held_data[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: flush > capture > release/hold.
  // Reset has the highest priority and is applied in the register process.
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_next   = valid_reg;
    pc_next      = pc_reg;
    rs1_next     = rs1_reg;
    rs2_next     = rs2_reg;
    rd_next      = rd_reg;
    rd1_next     = rd1_reg;
    rd2_next     = rd2_reg;
    imm_next     = imm_reg;
    ctrl_next    = ctrl_reg;
    is_load_next = is_load_reg;

    if (flush) begin
      // Kill the entry. The payload stays untouched; it is meaningless
      // while the entry is empty.
      valid_next = 1'b0;
    end else if (fire_in) begin
      valid_next   = 1'b1;
      pc_next      = in_pc;
      rs1_next     = in_rs1;
      rs2_next     = in_rs2;
      rd_next      = in_rd;
      rd1_next     = cap_data[0];
      rd2_next     = cap_data[1];
      imm_next     = in_imm;
      ctrl_next    = in_ctrl;
      is_load_next = in_is_load;
    end else begin
      // The entry was not replaced this edge, so keep its operands coherent
      // with the register file. If the entry leaves on this edge, the
      // refreshed copy is never observed as valid.
      if (valid_reg) begin
        rd1_next = ref_data[0];
        rd2_next = ref_data[1];
      end
      if (fire_out) begin
        valid_next = 1'b0;
      end
    end
  end

  // The counter saturates so a long run never reports a small count.
  always_comb begin
    bubble_cnt_next = bubble_cnt_reg;
    if (bubble_evt && (bubble_cnt_reg != BUBBLE_MAX)) begin
      bubble_cnt_next = bubble_cnt_reg + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg      <= 1'b0;
      pc_reg         <= '0;
      rs1_reg        <= '0;
      rs2_reg        <= '0;
      rd_reg         <= '0;
      rd1_reg        <= '0;
      rd2_reg        <= '0;
      imm_reg        <= '0;
      ctrl_reg       <= '0;
      is_load_reg    <= 1'b0;
      bubble_cnt_reg <= '0;
    end else begin
      valid_reg      <= valid_next;
      pc_reg         <= pc_next;
      rs1_reg        <= rs1_next;
      rs2_reg        <= rs2_next;
      rd_reg         <= rd_next;
      rd1_reg        <= rd1_next;
      rd2_reg        <= rd2_next;
      imm_reg        <= imm_next;
      ctrl_reg       <= ctrl_next;
      is_load_reg    <= is_load_next;
      bubble_cnt_reg <= bubble_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all registered)
  // ---------------------------------------------------------------------------
  assign out_valid   = valid_reg;
  assign out_pc      = pc_reg;
  assign out_rs1     = rs1_reg;
  assign out_rs2     = rs2_reg;
  assign out_rd      = rd_reg;
  assign out_rd1     = rd1_reg;
  assign out_rd2     = rd2_reg;
  assign out_imm     = imm_reg;
  assign out_ctrl    = ctrl_reg;
  assign out_is_load = is_load_reg;
  assign bubble_cnt  = bubble_cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed scenarios followed by a randomized phase. The reference model
// below describes the stage as one optional instruction slot, plus a queue of
// accepted PCs used to check ordering. After each step it is compared
// against the DUT.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int CTRL_W = 16;

  typedef struct packed {
    logic [31:0]       pc;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       rd1;
    logic [31:0]       rd2;
    logic [31:0]       imm;
    logic [CTRL_W-1:0] ctrl;
    logic              is_load;
  } instr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wd;
  instr_t      cur;

  logic              in_ready;
  logic              out_valid;
  logic [31:0]       out_pc;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [4:0]        out_rd;
  logic [31:0]       out_rd1;
  logic [31:0]       out_rd2;
  logic [31:0]       out_imm;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_is_load;
  logic [15:0]       bubble_cnt;

  id_ex_stage #(.CTRL_W(CTRL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (cur.pc),
    .in_rs1     (cur.rs1),
    .in_rs2     (cur.rs2),
    .in_rd      (cur.rd),
    .in_rd1     (cur.rd1),
    .in_rd2     (cur.rd2),
    .in_imm     (cur.imm),
    .in_ctrl    (cur.ctrl),
    .in_is_load (cur.is_load),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_wd      (wb_wd),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_rd     (out_rd),
    .out_rd1    (out_rd1),
    .out_rd2    (out_rd2),
    .out_imm    (out_imm),
    .out_ctrl   (out_ctrl),
    .out_is_load(out_is_load),
    .bubble_cnt (bubble_cnt)
  );

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  // ---------------- reference model ----------------
  instr_t      m_e;          // instruction held in the slot
  bit          m_full;       // slot occupied
  int          m_bub;        // bubbles seen, saturating at 65535
  logic [31:0] sb_q[$];      // PCs accepted but not yet delivered

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value the register file holds for rs this cycle, given the write-back.
  function automatic logic [31:0] reg_value(logic [4:0] rs, logic [31:0] d);
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs) return wb_wd;
    return d;
  endfunction

  function automatic bit m_hazard();
    return in_valid && m_full && m_e.is_load && m_e.rd != 5'd0 &&
           (m_e.rd == cur.rs1 || m_e.rd == cur.rs2);
  endfunction

  function automatic bit m_ready();
    return (!m_full || out_ready) && !m_hazard() && !flush;
  endfunction

  task automatic rand_cur();
    cur.pc      = $urandom;
    cur.rs1     = 5'($urandom_range(0, 7));
    cur.rs2     = 5'($urandom_range(0, 7));
    cur.rd      = 5'($urandom_range(0, 7));
    cur.rd1     = $urandom;
    cur.rd2     = $urandom;
    cur.imm     = $urandom;
    cur.ctrl    = CTRL_W'($urandom);
    cur.is_load = ($urandom_range(0, 9) < 3);
  endtask

  // One clock step. Inputs must already be driven. Checks the combinational
  // ready, advances the model by one edge, then checks registered outputs.
  task automatic step();
    bit          acc;
    bit          haz;
    bit          leave;
    logic [31:0] exp_pc;
    #1;
    chk("in_ready", in_ready, m_ready());
    acc   = in_valid && m_ready();
    haz   = m_hazard();
    leave = m_full && out_ready;

    // Ordering: each delivered instruction is the oldest accepted one.
    if (!rst && !flush && out_valid && out_ready) begin
      exp_pc = 'x;
      if (sb_q.size() > 0) exp_pc = sb_q.pop_front();
      chk("order_pc", out_pc, exp_pc);
    end

    if (rst) begin
      m_full = 1'b0;
      m_e    = '0;
      m_bub  = 0;
      sb_q.delete();
    end else if (flush) begin
      m_full = 1'b0;
      sb_q.delete();
    end else begin
      if (haz && leave) m_bub = (m_bub < 65535) ? m_bub + 1 : 65535;
      if (acc) begin
        m_e     = cur;
        m_e.rd1 = reg_value(cur.rs1, cur.rd1);
        m_e.rd2 = reg_value(cur.rs2, cur.rd2);
        m_full  = 1'b1;
        sb_q.push_back(cur.pc);
      end else begin
        if (m_full) begin
          m_e.rd1 = reg_value(m_e.rs1, m_e.rd1);
          m_e.rd2 = reg_value(m_e.rs2, m_e.rd2);
        end
        if (leave) m_full = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    step_no++;
    $display("step %0d rst=%b flush=%b in_v=%b in_pc=%h out_r=%b -> out_v=%b out_pc=%h rd1=%h rd2=%h bub=%0d",
             step_no, rst, flush, in_valid, cur.pc, out_ready, out_valid, out_pc, out_rd1, out_rd2, bubble_cnt);
    chk("out_valid", out_valid, m_full);
    chk("bubble_cnt", bubble_cnt, m_bub[15:0]);
    if (m_full) begin
      chk("payload", {out_pc, out_rs1, out_rs2, out_rd, out_imm, out_ctrl, out_is_load},
                     {m_e.pc, m_e.rs1, m_e.rs2, m_e.rd, m_e.imm, m_e.ctrl, m_e.is_load});
      chk("out_rd1", out_rd1, m_e.rd1);
      chk("out_rd2", out_rd2, m_e.rd2);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_bub"}, bubble_cnt, 16'd0);
    chk({tag, "_payload"},
        {out_pc, out_rs1, out_rs2, out_rd, out_rd1, out_rd2, out_imm, out_ctrl, out_is_load}, 192'd0);
  endtask

  // Self-dependent load: when held, it blocks its own successor copy.
  task automatic set_self_load(input logic [31:0] pc);
    cur         = '0;
    cur.pc      = pc;
    cur.rd      = 5'd5;
    cur.rs1     = 5'd5;
    cur.is_load = 1'b1;
  endtask

  logic [15:0] b0;

  initial begin
    rst = 1'b1; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_wd = '0;
    m_e = '0; m_full = 1'b0; m_bub = 0;
    rand_cur();

    // ---- reset ----
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk_reset_state("rst");
    #1 chk("ready_after_rst", in_ready, 1'b1);

    // ---- stream of non-loads ----
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_cur();
      cur.is_load = 1'b0;
      step();
      chk("stream_pc", out_pc, cur.pc);
      chk("stream_valid", out_valid, 1'b1);
    end
    chk("stream_bub", bubble_cnt, 16'd0);

    // ---- load-use bubble ----
    in_valid = 1'b0; step();
    cur = '0; cur.pc = 32'h100; cur.rd = 5'd5; cur.rs1 = 5'd1; cur.rs2 = 5'd2; cur.is_load = 1'b1;
    in_valid = 1'b1; step();
    b0 = bubble_cnt;
    cur = '0; cur.pc = 32'h104; cur.rs1 = 5'd5; cur.rs2 = 5'd6; cur.rd = 5'd7;
    #1 chk("lu_stall_ready", in_ready, 1'b0);
    step();
    chk("lu_bubble_valid", out_valid, 1'b0);
    chk("lu_bub", bubble_cnt, b0 + 16'd1);
    step();
    chk("lu_add_valid", out_valid, 1'b1);
    chk("lu_add_pc", out_pc, 32'h104);

    // ---- load to x0 never stalls ----
    in_valid = 1'b0; step();
    cur = '0; cur.pc = 32'h200; cur.rs1 = 5'd1; cur.is_load = 1'b1;
    in_valid = 1'b1; step();
    cur = '0; cur.pc = 32'h204; cur.rs1 = 5'd0;
    #1 chk("rd0_ready", in_ready, 1'b1);
    step();
    chk("rd0_pc", out_pc, 32'h204);

    // ---- capture bypass ----
    cur = '0; cur.pc = 32'h300; cur.rs1 = 5'd7; cur.rd1 = 32'h11;
    wb_we = 1'b1; wb_rd = 5'd7; wb_wd = 32'hDEADBEEF;
    step();
    chk("byp_hit", out_rd1, 32'hDEADBEEF);
    cur.pc = 32'h304; wb_rd = 5'd0;
    step();
    chk("byp_wb0", out_rd1, 32'h11);
    cur.pc = 32'h308; cur.rs1 = 5'd0;
    step();
    chk("byp_x0", out_rd1, 32'h11);
    cur.pc = 32'h30C; cur.rs1 = 5'd9; cur.rs2 = 5'd9; cur.rd1 = 32'h1; cur.rd2 = 32'h2;
    wb_rd = 5'd9; wb_wd = 32'hCAFE;
    step();
    chk("byp_both_rd1", out_rd1, 32'hCAFE);
    chk("byp_both_rd2", out_rd2, 32'hCAFE);
    wb_we = 1'b0;

    // ---- held-entry refresh under backpressure ----
    cur = '0; cur.pc = 32'h400; cur.rs2 = 5'd3; cur.rd2 = 32'h22;
    step();
    out_ready = 1'b0;
    cur = '0; cur.pc = 32'h404; cur.rs1 = 5'd1; cur.rs2 = 5'd2;
    wb_we = 1'b1; wb_rd = 5'd3; wb_wd = 32'h55;
    #1 chk("ref_ready", in_ready, 1'b0);
    step();
    chk("ref_rd2", out_rd2, 32'h55);
    chk("ref_pc", out_pc, 32'h400);
    wb_we = 1'b0;

    // ---- flush with hazard and backpressure ----
    out_ready = 1'b1; in_valid = 1'b0; step();
    cur = '0; cur.pc = 32'h500; cur.rd = 5'd5; cur.is_load = 1'b1;
    in_valid = 1'b1; step();
    out_ready = 1'b0; flush = 1'b1;
    cur = '0; cur.pc = 32'h504; cur.rs1 = 5'd5;
    b0 = bubble_cnt;
    #1 chk("flush_ready", in_ready, 1'b0);
    step();
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_bub", bubble_cnt, b0);
    flush = 1'b0;

    // ---- reset in the middle of a stall ----
    rst = 1'b1; in_valid = 1'b0; step(); rst = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_self_load(32'h600 + 32'(i * 4));
      step();
    end
    chk("stall_bub3", bubble_cnt, 16'd3);
    out_ready = 1'b0;
    set_self_load(32'h700); step();
    set_self_load(32'h704); step();
    chk("stall_full", out_valid, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    chk_reset_state("midrst");

    // ---- counter saturation ----
    in_valid = 1'b0; out_ready = 1'b1;
    force dut.bubble_cnt_reg = 16'hFFFD;
    #1 release dut.bubble_cnt_reg;
    m_bub = 65533;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_self_load(32'h800 + 32'(i * 4));
      step();
    end
    chk("sat_bub", bubble_cnt, 16'hFFFF);

    // ---- randomized traffic ----
    rst = 1'b1; in_valid = 1'b0; step(); rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rand_cur();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      wb_we     = $urandom_range(0, 1) == 1;
      wb_rd     = 5'($urandom_range(0, 7));
      wb_wd     = $urandom;
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
